// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: register index, issue FSM encoding and
// default configuration values.
package riscv_pkg;

  localparam int NREG_DEF         = 32;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback handshake bundle seen by the issue controller.
// master drives the pipeline side, slave is the issue controller.
interface issue_ctrl_if;
  import riscv_pkg::*;

  logic        dec_valid;
  reg_idx_t    dec_rs1;
  reg_idx_t    dec_rs2;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  reg_idx_t    dec_rd;
  logic        dec_rd_we;
  logic        dec_is_load;
  logic        ex_ready;
  logic        wb_valid;
  reg_idx_t    wb_rd;
  logic        br_taken;
  logic        issue_o;
  logic        stall_o;
  logic        flush_o;
  logic        fwd_rs1_o;
  logic        fwd_rs2_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_rd_we, dec_is_load, ex_ready, wb_valid, wb_rd, br_taken,
    input  issue_o, stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_rd_we, dec_is_load, ex_ready, wb_valid, wb_rd, br_taken,
    output issue_o, stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
// A set and a clear of the same register on one edge leaves it pending.
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rd_idx_a,
  input  reg_idx_t rd_idx_b,
  output logic     pend_a,
  output logic     pend_b
);

  logic [NREG-1:0] pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_idx] <= 1'b0;
      if (set_en) pending[set_idx] <= 1'b1;
      pending[0] <= 1'b0;
    end
  end

  assign pend_a = (rd_idx_a != '0) && pending[rd_idx_a];
  assign pend_b = (rd_idx_b != '0) && pending[rd_idx_b];

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: RAW hazard stall, branch flush, stall counter.
// Define ISSUE_CTRL_FWD_EN to enable EX-to-decode bypassing of non-load results.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  issue_ctrl_if.slave  bus
);

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  issue_state_e state, state_nxt;
  logic [2:0]   fcnt, fcnt_nxt;
  logic         ex_we;
  logic         ex_is_load;
  reg_idx_t     ex_rd;
  logic [31:0]  stall_cnt;

  logic pend1, pend2, byp1, byp2, hazard;
  logic issue, stall, flush, fwd1, fwd2;
  logic sb_set, sb_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign sb_set = issue && bus.dec_rd_we && (bus.dec_rd != '0);
  assign sb_clr = bus.wb_valid && (bus.wb_rd != '0);

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_idx  (bus.dec_rd),
    .clr_en   (sb_clr),
    .clr_idx  (bus.wb_rd),
    .rd_idx_a (bus.dec_rs1),
    .rd_idx_b (bus.dec_rs2),
    .pend_a   (pend1),
    .pend_b   (pend2)
  );

`ifdef ISSUE_CTRL_FWD_EN
  // Load data arrives too late in EX to bypass, so only ALU results qualify.
  assign byp1 = ex_we && !ex_is_load && (ex_rd == bus.dec_rs1) && (bus.dec_rs1 != '0);
  assign byp2 = ex_we && !ex_is_load && (ex_rd == bus.dec_rs2) && (bus.dec_rs2 != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hazard = (bus.dec_rs1_used && pend1 && !byp1) ||
                  (bus.dec_rs2_used && pend2 && !byp2);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    issue     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    fwd1      = 1'b0;
    fwd2      = 1'b0;
    // Outputs are forced low while reset is asserted, whatever the inputs do.
    if (rst) begin
      if (state == FLUSH) begin
        flush = 1'b1;
      end else begin
        issue = bus.dec_valid && bus.ex_ready && !hazard && !bus.br_taken;
        stall = bus.dec_valid && !issue;
      end
      fwd1 = bus.dec_valid && bus.dec_rs1_used && byp1;
      fwd2 = bus.dec_valid && bus.dec_rs2_used && byp2;
      if (bus.br_taken) begin
        state_nxt = FLUSH;
        fcnt_nxt  = FCNT_LOAD;
      end else begin
        unique case (state)
          RUN:     if (bus.dec_valid && !issue) state_nxt = STALL;
          STALL:   if (issue || !bus.dec_valid) state_nxt = RUN;
          FLUSH: begin
            if (fcnt == 3'd0) state_nxt = RUN;
            else              fcnt_nxt  = fcnt - 3'd1;
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      fcnt      <= 3'd0;
      ex_we     <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (issue)                           ex_we <= bus.dec_rd_we;
      else if (bus.br_taken || bus.ex_ready) ex_we <= 1'b0;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ex_rd      <= bus.dec_rd;
      ex_is_load <= bus.dec_is_load;
    end
  end

  assign bus.issue_o     = issue;
  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.fwd_rs1_o   = fwd1;
  assign bus.fwd_rs2_o   = fwd2;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; expectations follow ISSUE_CTRL_FWD_EN when defined.
module tb_issue_ctrl;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [31:0] sc_base;

  issue_ctrl_if bus();

  issue_ctrl #(.NREG(32), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.dec_valid    = 1'b0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.dec_rs1_used = 1'b0;
    bus.dec_rs2_used = 1'b0;
    bus.dec_rd       = '0;
    bus.dec_rd_we    = 1'b0;
    bus.dec_is_load  = 1'b0;
    bus.ex_ready     = 1'b1;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.br_taken     = 1'b0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    bus.dec_valid    = 1'b1;
    bus.dec_rs1      = rs1;
    bus.dec_rs1_used = u1;
    bus.dec_rs2      = rs2;
    bus.dec_rs2_used = u2;
    bus.dec_rd       = rd;
    bus.dec_rd_we    = we;
    bus.dec_is_load  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    idle();
    bus.dec_valid    = 1'b1;
    bus.dec_rs1      = 5'd3;
    bus.dec_rs1_used = 1'b1;
    bus.br_taken     = 1'b1;
    #2;
    check("rst_issue", bus.issue_o, 0);
    check("rst_stall", bus.stall_o, 0);
    check("rst_flush", bus.flush_o, 0);
    check("rst_fwd1", bus.fwd_rs1_o, 0);
    check("rst_fwd2", bus.fwd_rs2_o, 0);
    check("rst_cnt", bus.stall_cnt_o, 0);
    tick();
    tick();
    rst = 1'b1;
    idle();

    // add x5 then dependent reader of x5
    dec(0, 0, 0, 0, 5, 1, 0); #1;
    check("add5_issue", bus.issue_o, 1);
    tick();
    dec(5, 1, 0, 0, 6, 1, 0); #1;
`ifdef ISSUE_CTRL_FWD_EN
    sc_base = 32'd0;
    check("dep_issue", bus.issue_o, 1);
    check("dep_fwd1", bus.fwd_rs1_o, 1);
    check("dep_stall", bus.stall_o, 0);
    tick();
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    tick();
    bus.wb_rd = 5'd6;
    tick();
    idle();
    tick();
`else
    sc_base = 32'd2;
    check("dep_issue", bus.issue_o, 0);
    check("dep_stall", bus.stall_o, 1);
    check("dep_fwd1", bus.fwd_rs1_o, 0);
    tick();
    check("dep_stall2", bus.stall_o, 1);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; #1;
    check("dep_stall_wb", bus.stall_o, 1);
    tick();
    bus.wb_valid = 1'b0; #1;
    check("dep_issue_late", bus.issue_o, 1);
    check("dep_stall_late", bus.stall_o, 0);
    tick();
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd6;
    tick();
    idle();
    tick();
`endif
    check("cnt_dep", bus.stall_cnt_o, sc_base);

    // load x7 then reader of x7 on rs2: three stall cycles
    dec(0, 0, 0, 0, 7, 1, 1); #1;
    check("ld_issue", bus.issue_o, 1);
    tick();
    dec(0, 0, 7, 1, 0, 0, 0); #1;
    check("ld_use_stall1", bus.stall_o, 1);
    check("ld_use_fwd2", bus.fwd_rs2_o, 0);
    tick();
    check("ld_use_stall2", bus.stall_o, 1);
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; #1;
    check("ld_use_stall3", bus.stall_o, 1);
    tick();
    bus.wb_valid = 1'b0; #1;
    check("ld_use_issue", bus.issue_o, 1);
    tick();
    idle(); #1;
    check("cnt_ld", bus.stall_cnt_o, sc_base + 32'd3);

    // set and clear of x9 on one edge, then branch flush around a stalled reader
    dec(0, 0, 0, 0, 9, 1, 0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; #1;
    check("x9_issue", bus.issue_o, 1);
    tick();
    idle();
    tick();
    dec(9, 1, 0, 0, 0, 0, 0); #1;
    check("x9_pending", bus.stall_o, 1);
    tick();
    bus.br_taken = 1'b1; #1;
    check("br_issue", bus.issue_o, 0);
    check("br_flush", bus.flush_o, 0);
    check("br_stall", bus.stall_o, 1);
    tick();
    bus.br_taken = 1'b0; #1;
    check("flush1", bus.flush_o, 1);
    check("flush1_issue", bus.issue_o, 0);
    check("flush1_stall", bus.stall_o, 0);
    tick();
    check("flush2", bus.flush_o, 1);
    tick();
    check("flush_end", bus.flush_o, 0);
    check("x9_after_flush", bus.stall_o, 1);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9;
    tick();
    bus.wb_valid = 1'b0; #1;
    check("x9_issue_late", bus.issue_o, 1);
    tick();
    idle(); #1;
    check("cnt_br", bus.stall_cnt_o, sc_base + 32'd6);

    // x0 writer then x0 reader
    dec(0, 0, 0, 0, 0, 1, 0); #1;
    check("x0_wr_issue", bus.issue_o, 1);
    tick();
    dec(0, 1, 0, 1, 0, 0, 0); #1;
    check("x0_rd_issue", bus.issue_o, 1);
    check("x0_rd_stall", bus.stall_o, 0);
    check("x0_rd_fwd1", bus.fwd_rs1_o, 0);
    check("x0_rd_fwd2", bus.fwd_rs2_o, 0);
    tick();
    idle();

    // reset during a stall on x3
    dec(0, 0, 0, 0, 3, 1, 0);
    tick();
    idle();
    tick();
    dec(3, 1, 0, 0, 0, 0, 0); #1;
    check("x3_stall", bus.stall_o, 1);
    tick();
    check("x3_stall2", bus.stall_o, 1);
    rst = 1'b0; #1;
    check("mid_rst_issue", bus.issue_o, 0);
    check("mid_rst_stall", bus.stall_o, 0);
    check("mid_rst_flush", bus.flush_o, 0);
    check("mid_rst_fwd1", bus.fwd_rs1_o, 0);
    check("mid_rst_cnt", bus.stall_cnt_o, 0);
    tick();
    rst = 1'b1; #1;
    check("post_rst_issue", bus.issue_o, 1);
    check("post_rst_stall", bus.stall_o, 0);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
